// File: rtl/vga_pixel_sink.sv
`default_nettype none
// ============================================================================
// Module   : vga_pixel_sink
// Purpose  : Buffers VGA write strobes, range-checks them, linearises the
//            coordinates and drains them into a shared framebuffer write port.
//            Optional macro VGA_PIXEL_SINK_CLEAR_ON_RESET_EN adds a post-reset
//            clear sweep.
// Revision : 1.0 - initial release
// ============================================================================
module vga_pixel_sink #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned H_RES        = 160,
  parameter int unsigned V_RES        = 120,
  parameter logic [8:0]  CLEAR_COLOUR = 9'h000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [8:0]               colour,
  input  logic [14:0]              coordinates,
  input  logic                     VGA_write_enable,
  input  logic                     fb_grant,
  output logic [14:0]              fb_address,
  output logic [8:0]               fb_data,
  output logic                     fb_wren,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               overflow_count,
  output logic [7:0]               range_drop_count,
  output logic                     busy
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);
`ifdef VGA_PIXEL_SINK_CLEAR_ON_RESET_EN
  localparam logic [14:0] c_CLR_LAST = 15'(H_RES * V_RES - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [23:0]       r_mem [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_CW-1:0]   r_count;
  logic [14:0]       r_fb_addr;
  logic [8:0]        r_fb_data;
  logic [7:0]        r_ovf_cnt;
  logic [7:0]        r_rng_cnt;

  logic [7:0]        w_x;
  logic [6:0]        w_y;
  logic [14:0]       w_addr;
  logic              w_in_range;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_ovf;
  logic              w_rng;
  logic              w_pop;
  logic              w_wr_slot;

  assign w_x        = coordinates[14:7];
  assign w_y        = coordinates[6:0];
  assign w_in_range = (32'(w_x) < H_RES) && (32'(w_y) < V_RES);
  assign w_full     = (r_count == c_FULL);
  assign w_empty    = (r_count == '0);

  // Fullness is judged on the pre-edge count, so a same-cycle pop never frees a slot.
  assign w_push = VGA_write_enable && w_in_range && !w_full;
  assign w_ovf  = VGA_write_enable && w_in_range &&  w_full;
  assign w_rng  = VGA_write_enable && !w_in_range;

  generate
    if (H_RES == 160) begin : g_addr_shift
      assign w_addr = ({8'd0, w_y} << 7) + ({8'd0, w_y} << 5) + {7'd0, w_x};
    end else begin : g_addr_mul
      assign w_addr = 15'(32'(w_y) * H_RES + 32'(w_x));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_addr, colour};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef VGA_PIXEL_SINK_CLEAR_ON_RESET_EN
      r_state <= ST_CLEAR;
`else
      r_state <= ST_IDLE;
`endif
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_wr_slot   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        w_wr_slot = 1'b1;
        if (fb_grant) begin
          if (!w_empty) begin
            w_pop = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
`ifdef VGA_PIXEL_SINK_CLEAR_ON_RESET_EN
      ST_CLEAR: begin
        w_wr_slot = 1'b1;
        if (fb_grant && (r_fb_addr == c_CLR_LAST)) begin
          w_state_nxt = ST_IDLE;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_fb_addr <= '0;
      r_fb_data <= '0;
      r_ovf_cnt <= '0;
      r_rng_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        {r_fb_addr, r_fb_data} <= r_mem[r_rd_ptr];
        r_rd_ptr               <= r_rd_ptr + 1'b1;
      end
`ifdef VGA_PIXEL_SINK_CLEAR_ON_RESET_EN
      // The clear sweep reuses the address register as its cursor.
      if ((r_state == ST_CLEAR) && fb_grant && (r_fb_addr != c_CLR_LAST)) begin
        r_fb_addr <= r_fb_addr + 1'b1;
      end
`endif
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_ovf && (r_ovf_cnt != 8'hFF)) begin
        r_ovf_cnt <= r_ovf_cnt + 1'b1;
      end
      if (w_rng && (r_rng_cnt != 8'hFF)) begin
        r_rng_cnt <= r_rng_cnt + 1'b1;
      end
    end
  end

  assign fb_wren    = w_wr_slot && fb_grant && !reset;
  assign fb_address = r_fb_addr;
`ifdef VGA_PIXEL_SINK_CLEAR_ON_RESET_EN
  assign fb_data    = (r_state == ST_CLEAR) ? CLEAR_COLOUR : r_fb_data;
`else
  assign fb_data    = r_fb_data;
`endif
  assign fifo_count       = r_count;
  assign overflow_count   = r_ovf_cnt;
  assign range_drop_count = r_rng_cnt;
  assign busy             = (r_state != ST_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_pixel_sink
// Purpose  : Self-checking bench for vga_pixel_sink: directed vectors, corner
//            sequences and randomized traffic against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_pixel_sink;

  localparam int DEPTH = 16;
  localparam int H_RES = 160;
  localparam int V_RES = 120;
  localparam logic [8:0] CLR_COL = 9'h000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [8:0]  colour = '0;
  logic [14:0] coordinates = '0;
  logic        VGA_write_enable = 1'b0;
  logic        fb_grant = 1'b0;
  logic [14:0] fb_address;
  logic [8:0]  fb_data;
  logic        fb_wren;
  logic [4:0]  fifo_count;
  logic [7:0]  overflow_count;
  logic [7:0]  range_drop_count;
  logic        busy;

  always #5 clk = ~clk;

  vga_pixel_sink #(
    .DEPTH(DEPTH), .H_RES(H_RES), .V_RES(V_RES), .CLEAR_COLOUR(CLR_COL)
  ) dut (
    .clk(clk), .reset(reset), .colour(colour), .coordinates(coordinates),
    .VGA_write_enable(VGA_write_enable), .fb_grant(fb_grant),
    .fb_address(fb_address), .fb_data(fb_data), .fb_wren(fb_wren),
    .fifo_count(fifo_count), .overflow_count(overflow_count),
    .range_drop_count(range_drop_count), .busy(busy)
  );

  int checks = 0;
  int errs   = 0;
  int cyc    = 0;
  int nwrites = 0;
  int last_wr_cyc = -1;
  int last_wr_addr = -1;
  int last_wr_data = -1;

  // Reference model: every accepted write waits in q; q[0] sits in the
  // output slot whenever 'held' is set.
  typedef struct packed {
    logic [14:0] a;
    logic [8:0]  d;
  } wr_t;
  wr_t q[$];
  bit  held = 1'b0;
  bit  clearing = 1'b0;
  bit  valid = 1'b0;
  int  clr_addr = 0;
  int  m_ovf = 0;
  int  m_rng = 0;

  typedef struct {
    int x;
    int y;
    int col;
    int exp_addr;
    bit exp_ok;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s cycle %0d actual %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input bit rst, input bit we, input logic [8:0] col,
                      input logic [7:0] x, input logic [6:0] y, input bit gnt);
    int  fpre;
    bit  hold_next;
    @(negedge clk);
    reset            = rst;
    VGA_write_enable = we;
    colour           = col;
    coordinates      = {x, y};
    fb_grant         = gnt;
    #1;
    if (valid) begin
      fpre = q.size() - (held ? 1 : 0);
      chk("wren", int'(fb_wren), int'(!rst && gnt && (held || clearing)));
      if (held) begin
        chk("hold_addr", int'(fb_address), int'(q[0].a));
        chk("hold_data", int'(fb_data), int'(q[0].d));
      end
      if (clearing) begin
        chk("clr_addr", int'(fb_address), clr_addr);
        chk("clr_data", int'(fb_data), int'(CLR_COL));
      end
      chk("fifo_count", int'(fifo_count), fpre);
      chk("busy", int'(busy), int'(held || clearing || fpre > 0));
      chk("ovf_cnt", int'(overflow_count), m_ovf);
      chk("rng_cnt", int'(range_drop_count), m_rng);
    end
    if (fb_wren) begin
      nwrites++;
      last_wr_cyc  = cyc;
      last_wr_addr = int'(fb_address);
      last_wr_data = int'(fb_data);
    end
    if (rst) begin
      q.delete();
      held  = 1'b0;
      m_ovf = 0;
      m_rng = 0;
      valid = 1'b1;
      clr_addr = 0;
`ifdef VGA_PIXEL_SINK_CLEAR_ON_RESET_EN
      clearing = 1'b1;
`else
      clearing = 1'b0;
`endif
    end else begin
      fpre      = q.size() - (held ? 1 : 0);
      hold_next = clearing ? 1'b0 : ((held && !gnt) || fpre > 0);
      if (we) begin
        if (int'(x) >= H_RES || int'(y) >= V_RES) begin
          if (m_rng < 255) m_rng++;
        end else if (fpre == DEPTH) begin
          if (m_ovf < 255) m_ovf++;
        end else begin
          q.push_back({15'(int'(y) * H_RES + int'(x)), col});
        end
      end
      if (held && gnt) void'(q.pop_front());
      if (clearing && gnt) begin
        if (clr_addr == H_RES * V_RES - 1) clearing = 1'b0;
        else clr_addr++;
      end
      held = hold_next;
    end
    cyc++;
  endtask

  task automatic idle(input int n, input bit gnt);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 9'h0, 8'd0, 7'd0, gnt);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 9'h0, 8'd0, 7'd0, 1'b0);
  endtask

  vec_t vecs[6];

  initial begin
    int w0;
    int sc;
    int f;
    vecs[0] = '{x: 0,   y: 0,   col: 9'h007, exp_addr: 0,     exp_ok: 1'b1};
    vecs[1] = '{x: 159, y: 119, col: 9'h038, exp_addr: 19199, exp_ok: 1'b1};
    vecs[2] = '{x: 160, y: 0,   col: 9'h1FF, exp_addr: 0,     exp_ok: 1'b0};
    vecs[3] = '{x: 0,   y: 120, col: 9'h1FF, exp_addr: 0,     exp_ok: 1'b0};
    vecs[4] = '{x: 3,   y: 1,   col: 9'h0AA, exp_addr: 163,   exp_ok: 1'b1};
    vecs[5] = '{x: 10,  y: 5,   col: 9'h1C0, exp_addr: 810,   exp_ok: 1'b1};

    do_reset();
    do_reset();

`ifdef VGA_PIXEL_SINK_CLEAR_ON_RESET_EN
    w0 = nwrites;
    for (int k = 0; k < 20000 && busy; k++)
      step(1'b0, k == 5000, 9'h155, 8'd7, 7'd3, 1'b1);
    chk("clear_writes", nwrites - w0, 19201);
    chk("clear_last_addr", last_wr_addr, 487);
    chk("clear_last_data", last_wr_data, 9'h155);
    chk("clear_busy_end", int'(busy), 0);
`else
    idle(1, 1'b1);
    chk("rst_addr", int'(fb_address), 0);
    chk("rst_data", int'(fb_data), 0);
    chk("rst_fifo", int'(fifo_count), 0);
    chk("rst_busy", int'(busy), 0);

    // Single write latency
    step(1'b0, 1'b1, 9'h1C0, 8'd10, 7'd5, 1'b1);
    sc = cyc - 1;
    idle(2, 1'b1);
    chk("single_latency", last_wr_cyc - sc, 2);
    chk("single_addr", last_wr_addr, 810);
    chk("single_data", last_wr_data, 9'h1C0);
    idle(1, 1'b1);
    chk("single_busy_after", int'(busy), 0);

    // Vector table: corners and range drops
    do_reset();
    for (int i = 0; i < 6; i++) begin
      int r0;
      w0 = nwrites;
      r0 = m_rng;
      step(1'b0, 1'b1, 9'(vecs[i].col), 8'(vecs[i].x), 7'(vecs[i].y), 1'b1);
      idle(4, 1'b1);
      chk("vec_writes", nwrites - w0, vecs[i].exp_ok ? 1 : 0);
      if (vecs[i].exp_ok) begin
        chk("vec_addr", last_wr_addr, vecs[i].exp_addr);
        chk("vec_data", last_wr_data, vecs[i].col);
      end
      chk("vec_rng_delta", int'(range_drop_count) - r0, vecs[i].exp_ok ? 0 : 1);
    end
    chk("vec_rng_total", int'(range_drop_count), 2);

    // Overflow with the port withheld
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 9'(i + 1), 8'(i), 7'(i), 1'b0);
    idle(1, 1'b0);
    chk("ovf_fifo_full", int'(fifo_count), 16);
    chk("ovf_count", int'(overflow_count), 3);
    w0 = nwrites;
    f  = -1;
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 1'b0, 9'h0, 8'd0, 7'd0, 1'b1);
      if (f < 0 && nwrites == w0 + 1) f = last_wr_cyc;
    end
    chk("ovf_drain_writes", nwrites - w0, 17);
    chk("ovf_drain_span", last_wr_cyc - f, 16);
    chk("ovf_drain_last", last_wr_addr, 16 * H_RES + 16);

    // Grant toggling
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 9'(9'h100 + i), 8'(20 + i), 7'(2), 1'b0);
    idle(1, 1'b0);
    w0 = nwrites;
    for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 9'h0, 8'd0, 7'd0, (k % 2) == 0);
    chk("toggle_writes", nwrites - w0, 4);
    chk("toggle_last", last_wr_addr, 2 * H_RES + 23);

    // Reset while writing with a backlog
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 9'(i), 8'(i), 7'(9), 1'b0);
    idle(1, 1'b0);
    chk("midrst_fifo", int'(fifo_count), 5);
    step(1'b1, 1'b0, 9'h0, 8'd0, 7'd0, 1'b1);
    chk("midrst_wren", int'(fb_wren), 0);
    w0 = nwrites;
    idle(10, 1'b1);
    chk("midrst_no_writes", nwrites - w0, 0);
    chk("midrst_fifo_after", int'(fifo_count), 0);
    chk("midrst_busy_after", int'(busy), 0);

    // Randomized traffic
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      bit gnt;
      gnt = ((k / 500) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(1'b0, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)),
           8'($urandom_range(0, 175)), 7'($urandom_range(0, 127)), gnt);
    end
    idle(60, 1'b1);
    chk("rand_drained", q.size(), 0);
    chk("rand_busy_end", int'(busy), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_pixel_sink.md
Name: vga_pixel_sink

Overview:
- Receiving end of the game datapath's VGA write stream (colour, coordinates, VGA_write_enable).
- Buffers one-cycle write strobes in a FIFO, range-checks them, converts the packed coordinates to a linear address, and drains them into the framebuffer write port.
- The framebuffer write port is shared with another master, so draining only proceeds on granted cycles.

Parameters:
- DEPTH, 16: FIFO entries; power of two, ≥2.
- H_RES, 160: pixels per line.
- V_RES, 120: lines per frame.
- CLEAR_COLOUR, 9'h000: fill colour used by the optional clear sweep.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- colour  in  9  pixel colour, 3 bits per channel.
- coordinates  in  15  packed as {x[7:0], y[6:0]}: x = coordinates[14:7], y = coordinates[6:0].
- VGA_write_enable  in  1  one-cycle write strobe; no backpressure to the producer.
- fb_grant  in  1  framebuffer write port is available this cycle.
- fb_address  out  15  linear address, y*H_RES + x.
- fb_data  out  9  colour to write.
- fb_wren  out  1  framebuffer write strobe.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow_count  out  8  writes dropped because the FIFO was full; saturates at 255.
- range_drop_count  out  8  writes dropped for x≥H_RES or y≥V_RES; saturates at 255.
- busy  out  1  FIFO non-empty, write pending, or clear in progress.

Behaviour:
- Reset (sampled on a clk edge while reset=1):
  - FIFO flushed; state forced to IDLE, or to CLEAR when the optional feature is compiled in.
  - All counters cleared to 0; fb_address=0, fb_data=0.
  - fb_wren is gated low combinationally while reset=1, including mid-write.
- Push path, evaluated at each edge where VGA_write_enable=1:
  - Out of range (x≥H_RES or y≥V_RES): not enqueued; range_drop_count+1 (saturating).
  - In range and FIFO full (count==DEPTH before the edge): not enqueued; overflow_count+1 (saturating). A pop in the same cycle does not free the slot for this push.
  - Otherwise: {address, colour} enqueued.
- Address computation:
  - Done at push time as (y<<7)+(y<<5)+x when H_RES=160, otherwise y*H_RES+x.
  - Result truncated to 15 bits; no overflow is possible for in-range coordinates.
- Drain FSM:
  - IDLE: if FIFO non-empty, pop the head into the fb_address/fb_data registers, then go to WRITE.
  - WRITE: fb_wren = fb_grant && !reset. fb_address/fb_data are held stable until a granted cycle. On a granted edge: if FIFO non-empty, pop the next entry and stay in WRITE; else go to IDLE.
  - CLEAR: optional; see below.
- Throughput and latency:
  - Sustains one pixel per clock while fb_grant=1.
  - Minimum latency: strobe sampled at edge t0, popped at t1, fb_wren high in the cycle after t1 (2 cycles after the strobe cycle) when granted.
- Simultaneous push and pop: occupancy is unchanged; FIFO pointers wrap modulo DEPTH.
- Ordering: writes reach the framebuffer in strobe order. Two writes to the same address are both performed; the last one wins.
- fifo_count excludes the entry held in the output registers. busy = (state≠IDLE) || fifo_count≠0.

Optional Feature:
- Macro: VGA_PIXEL_SINK_CLEAR_ON_RESET_EN.
- Defined:
  - After reset the FSM enters CLEAR and writes CLEAR_COLOUR to addresses 0 through H_RES*V_RES-1, one per granted cycle, using the same fb_wren gating as WRITE.
  - Then it goes to IDLE.
  - Input strobes are still pushed during CLEAR (overflow rules apply) and drain afterwards.
  - busy=1 throughout CLEAR.
- Not defined: the CLEAR state does not exist, and reset goes directly to IDLE.

Test Plan:
- Single write, x=10, y=5, colour=9'h1C0, fb_grant=1 → fb_wren high exactly 2 cycles after the strobe cycle; fb_address=810, fb_data=9'h1C0; busy low the following cycle.
- Corner pixels: (0,0) → address 0; (159,119) → address 19199. Strobes with x=160 or y=120 → no fb_wren; range_drop_count=2.
- fb_grant=0, 20 consecutive strobes with DEPTH=16 → fifo_count=16 and overflow_count=3 (16 queued, 1 in the output registers). Then fb_grant=1 → 17 fb_wren pulses on consecutive cycles, in strobe order.
- fb_grant toggling 1,0,1,0 with 4 queued writes → each write is held with fb_address/fb_data stable across the 0 cycles; exactly 4 pulses in total, no duplicates.
- Assert reset while in WRITE with 5 entries queued → fb_wren low during the reset cycle; afterwards fifo_count=0, counters 0, and no further writes appear.
- With VGA_PIXEL_SINK_CLEAR_ON_RESET_EN defined and fb_grant=1, reset → 19200 consecutive writes of CLEAR_COLOUR at addresses 0 through 19199, then busy falls. A strobe injected mid-clear is written after address 19199.
